// File: rtl/reg_file_seq_pkg.sv
// Shared types and default parameters for the register file with PC sequencer.
package regfile_pkg;

  // PC sequencer states: SAMPLE captures the PC, HOLD waits between samples
  typedef enum logic {
    SAMPLE = 1'b0,
    HOLD   = 1'b1
  } pc_state_t;

  // Default geometry of the register file
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_PC_IDX   = 15;
  localparam int DEF_PC_W     = 4;
  localparam int DEF_PC_HOLD  = 6;

  // Width of the hold counter: must represent 0 .. PC_HOLD-1 and stay
  // at least one bit wide for the smallest legal hold.
  function automatic int pc_cnt_width(input int hold);
    int w;
    w = $clog2(hold + 1);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage : regfile_pkg

// File: rtl/reg_file_seq_if.sv
// Bus between the control unit / datapath and the register file.
// The master drives addresses, write data and PC controls; the slave
// (register file) returns read data and the sampled PC.
interface reg_file_seq_if
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int PC_W     = DEF_PC_W
);
  localparam int AW = $clog2(NUM_REGS);

  logic [AW-1:0]     IR_ARn;
  logic [AW-1:0]     IR_ARs;
  logic [AW-1:0]     IR_ARm;
  logic [AW-1:0]     wr_addr;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [PC_W-1:0]   PC_next;
  logic              pc_stall;
  logic [DATA_W-1:0] Rn;
  logic [DATA_W-1:0] Rs;
  logic [DATA_W-1:0] Rm;
  logic [DATA_W-1:0] Rd;
  logic [PC_W-1:0]   PC_out;
  logic              pc_update;

  modport master (
    output IR_ARn, IR_ARs, IR_ARm, wr_addr, wr_en, wr_data, PC_next, pc_stall,
    input  Rn, Rs, Rm, Rd, PC_out, pc_update
  );

  modport slave (
    input  IR_ARn, IR_ARs, IR_ARm, wr_addr, wr_en, wr_data, PC_next, pc_stall,
    output Rn, Rs, Rm, Rd, PC_out, pc_update
  );

endinterface : reg_file_seq_if

// File: rtl/reg_file_seq_pc_sequencer.sv
// PC sequencer: samples the PC value once every PC_HOLD+1 unstalled cycles
// and pulses pc_update in the cycle PC_out takes the new sample.
module pc_sequencer
  import regfile_pkg::*;
#(
  parameter int PC_W    = DEF_PC_W,
  parameter int PC_HOLD = DEF_PC_HOLD
) (
  input  logic            CLOCK_50,
  input  logic            RESET,
  input  logic [PC_W-1:0] pc_value,
  input  logic            pc_stall,
  output logic [PC_W-1:0] PC_out,
  output logic            pc_update
);

  localparam int CW = pc_cnt_width(PC_HOLD);
  localparam logic [CW-1:0] CNT_LAST = CW'(PC_HOLD - 1);

  pc_state_t       r_state;
  logic [CW-1:0]   r_cnt;
  logic [PC_W-1:0] r_pc_out;
  logic            r_pc_update;

  // FSM with registered outputs; a stall freezes everything but drops the pulse
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_state     <= SAMPLE;
      r_cnt       <= '0;
      r_pc_out    <= '0;
      r_pc_update <= 1'b0;
    end else if (pc_stall) begin
      r_pc_update <= 1'b0;
    end else begin
      case (r_state)
        SAMPLE: begin
          r_pc_out    <= pc_value;
          r_pc_update <= 1'b1;
          r_cnt       <= '0;
          r_state     <= HOLD;
        end
        HOLD: begin
          r_pc_update <= 1'b0;
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= SAMPLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_pc_update <= 1'b0;
          r_cnt       <= '0;
          r_state     <= SAMPLE;
        end
      endcase
    end
  end

  assign PC_out    = r_pc_out;
  assign pc_update = r_pc_update;

endmodule : pc_sequencer

// File: rtl/reg_file_seq.sv
// Register file with three read ports, a destination read-back port, one
// write port, write-first forwarding and a PC register refreshed from
// PC_next every cycle unless an explicit write targets it.
module reg_file_seq
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int PC_IDX   = DEF_PC_IDX,
  parameter int PC_W     = DEF_PC_W,
  parameter int PC_HOLD  = DEF_PC_HOLD
) (
  input  logic           CLOCK_50,
  input  logic           RESET,
  reg_file_seq_if.slave  bus
);

  localparam int AW = $clog2(NUM_REGS);

  // Elaboration-time sanity checks on the parameter set
  if (PC_HOLD < 1) begin : g_chk_hold
    $error("PC_HOLD must be at least 1");
  end
  if (PC_IDX >= NUM_REGS) begin : g_chk_pc_idx
    $error("PC_IDX must address an existing register");
  end
  if (PC_W > DATA_W) begin : g_chk_pc_w
    $error("PC_W must not exceed DATA_W");
  end

  // Value every register holds after the current edge; reads use it so a
  // same-cycle write or PC refresh is visible immediately (write-first).
  logic [DATA_W-1:0] w_reg_next [NUM_REGS];
  logic [DATA_W-1:0] w_pc_ext;
  logic [PC_W-1:0]   w_pc_value;

  assign w_pc_ext = DATA_W'(bus.PC_next);

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic              w_wr_hit;
    logic [DATA_W-1:0] r_reg;

    assign w_wr_hit = bus.wr_en && (bus.wr_addr == AW'(gi));

    if (gi == PC_IDX) begin : g_pc
      // Explicit writes win over the per-cycle PC refresh
      assign w_reg_next[gi] = w_wr_hit ? bus.wr_data : w_pc_ext;
    end else begin : g_gp
      assign w_reg_next[gi] = w_wr_hit ? bus.wr_data : r_reg;
    end

    // Storage element; reset clears it regardless of any write in flight
    always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
        r_reg <= '0;
      end else begin
        r_reg <= w_reg_next[gi];
      end
    end
  end

  logic [DATA_W-1:0] r_rn;
  logic [DATA_W-1:0] r_rs;
  logic [DATA_W-1:0] r_rm;
  logic [DATA_W-1:0] r_rd;

  // Registered read ports, one cycle latency, forwarding the post-edge value
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_rn <= '0;
      r_rs <= '0;
      r_rm <= '0;
      r_rd <= '0;
    end else begin
      r_rn <= w_reg_next[bus.IR_ARn];
      r_rs <= w_reg_next[bus.IR_ARs];
      r_rm <= w_reg_next[bus.IR_ARm];
      r_rd <= w_reg_next[bus.wr_addr];
    end
  end

  assign bus.Rn = r_rn;
  assign bus.Rs = r_rs;
  assign bus.Rm = r_rm;
  assign bus.Rd = r_rd;

  // The sequencer samples the PC register as it will be after this edge
  assign w_pc_value = w_reg_next[PC_IDX][PC_W-1:0];

  pc_sequencer #(
    .PC_W    (PC_W),
    .PC_HOLD (PC_HOLD)
  ) u_pc_sequencer (
    .CLOCK_50  (CLOCK_50),
    .RESET     (RESET),
    .pc_value  (w_pc_value),
    .pc_stall  (bus.pc_stall),
    .PC_out    (bus.PC_out),
    .pc_update (bus.pc_update)
  );

endmodule : reg_file_seq
